// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_pkg
//  Brief    : Shared constants, event layout and FSM encoding for the keyboard
//             debounce/event block. Optional macro: KBD_EVT_TSTAMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam int ROWS  = 9;
    localparam int COLS  = 10;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;
    localparam int CNT_W = 2;
    localparam int KEYS  = ROWS * COLS;

    // Event layout: {[tstamp,] pressed, row, col}
    localparam int EVT_COL_LSB = 0;
    localparam int EVT_ROW_LSB = COL_W;
    localparam int EVT_PRS_BIT = COL_W + ROW_W;
    localparam int BASE_EW     = 1 + ROW_W + COL_W;

`ifdef KBD_EVT_TSTAMP_EN
    localparam int TS_W       = 16;
    localparam int EVT_TS_LSB = BASE_EW;
    localparam int EW         = BASE_EW + TS_W;
`else
    localparam int EW         = BASE_EW;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } kbd_state_e;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [ROW_W-1:0] lowest_set(input logic [ROWS-1:0] v);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_evt_fifo
//  Brief    : Synchronous event FIFO; a push into a full FIFO is taken when a
//             pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_evt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_aw-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[c_aw-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule
`default_nettype wire

// File: rtl/kbd_debounce_event.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_debounce_event
//  Brief    : Debounces the 9x10 key matrix from per-column samples and queues
//             key-down/key-up events. Optional macro: KBD_EVT_TSTAMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_debounce_event
    import kbd_pkg::*;
#(
    parameter int DEB_FRAMES = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             col_valid,
    output logic             col_ready,
    input  logic [COL_W-1:0] col_idx,
    input  logic [ROWS-1:0]  col_rows,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EW-1:0]    evt_data,
    output logic [KEYS-1:0]  key_state,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] c_deb_max = CNT_W'(DEB_FRAMES - 1);

    kbd_state_e       r_state;
    kbd_state_e       w_state_nxt;
    logic [KEYS-1:0]  r_key_state;
    logic [CNT_W-1:0] r_cnt [KEYS];
    logic [ROWS-1:0]  r_chg;
    logic [ROWS-1:0]  r_newv;
    logic [COL_W-1:0] r_col;
    logic             r_ovf;

    logic             w_accept;
    logic             w_sample;
    logic [ROWS-1:0]  w_cur_stable;
    logic [CNT_W-1:0] w_cur_cnt [ROWS];
    logic [ROWS-1:0]  w_chg;
    logic [ROW_W-1:0] w_row;
    logic [ROWS-1:0]  w_onehot;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [EW-1:0]    w_evt;

    assign w_accept = col_valid && (r_state == IDLE);
    assign w_sample = w_accept && (col_idx < COL_W'(COLS));

    // Stable value and count of every row of the presented column.
    always_comb begin
        w_cur_stable = '0;
        for (int r = 0; r < ROWS; r++) w_cur_cnt[r] = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_idx == COL_W'(c)) begin
                for (int r = 0; r < ROWS; r++) begin
                    w_cur_stable[r] = r_key_state[c*ROWS + r];
                    w_cur_cnt[r]    = r_cnt[c*ROWS + r];
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign w_chg[r] = w_sample && (col_rows[r] != w_cur_stable[r]) &&
                              (w_cur_cnt[r] == c_deb_max);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_state <= '0;
            for (int k = 0; k < KEYS; k++) r_cnt[k] <= '0;
        end else if (w_sample) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_idx == COL_W'(c)) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (col_rows[r] == r_key_state[c*ROWS + r]) begin
                            r_cnt[c*ROWS + r] <= '0;
                        end else if (r_cnt[c*ROWS + r] == c_deb_max) begin
                            r_key_state[c*ROWS + r] <= col_rows[r];
                            r_cnt[c*ROWS + r]       <= '0;
                        end else begin
                            r_cnt[c*ROWS + r] <= r_cnt[c*ROWS + r] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign w_row    = lowest_set(r_chg);
    assign w_onehot = ROWS'(1) << w_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_chg   <= '0;
            r_newv  <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                if (|w_chg) begin
                    r_chg  <= w_chg;
                    r_newv <= col_rows;
                    r_col  <= col_idx;
                end
            end else begin
                r_chg <= r_chg & ~w_onehot;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        col_ready   = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                col_ready = 1'b1;
                if (|w_chg) w_state_nxt = EMIT;
            end
            EMIT: begin
                w_push = 1'b1;
                if ((r_chg & ~w_onehot) == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef KBD_EVT_TSTAMP_EN
    logic [TS_W-1:0] r_tstamp;

    // Counts completed scan frames; wraps naturally at 0xFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tstamp <= '0;
        end else if (w_accept && (col_idx == COL_W'(COLS - 1))) begin
            r_tstamp <= r_tstamp + 1'b1;
        end
    end

    assign w_evt = {r_tstamp, r_newv[w_row], w_row, r_col};
`else
    assign w_evt = {r_newv[w_row], w_row, r_col};
`endif

    kbd_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (evt_ready),
        .o_data  (evt_data),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // A full FIFO is never empty, so evt_ready alone means a real pop.
    assign w_drop = w_push && w_full && !evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt_valid = !w_empty;
    assign key_state = r_key_state;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
